// File: rtl/parity_frame_ctrl.sv
// ============================================================================
// parity_frame_ctrl : serial framer (start, DATA_W bits LSB first, parity, stop)
// Optional macro PARITY_ODD_EN selects odd parity; even parity otherwise.
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module parity_frame_ctrl #(
  parameter int DATA_W     = 8,
  parameter int BIT_CYCLES = 4
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic [DATA_W-1:0] data_in,
  input  logic              valid_in,
  output logic              ready,
  output logic              tx_out,
  output logic              busy,
  output logic              frame_done
);

  localparam int CNT_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  bit_cnt;
  logic [IDX_W-1:0]  bit_idx;
  logic [DATA_W-1:0] shift_reg;
  logic              parity_bit;
  logic              parity_calc;
  logic              bit_end;

`ifdef PARITY_ODD_EN
  assign parity_calc = ~(^data_in);
`else
  assign parity_calc = ^data_in;
`endif

  assign bit_end = (bit_cnt == CNT_LAST);

  // tx_out is registered one state ahead: each transition loads the next bit.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state      <= ST_IDLE;
      bit_cnt    <= '0;
      bit_idx    <= '0;
      shift_reg  <= '0;
      parity_bit <= 1'b0;
      tx_out     <= 1'b1;
      ready      <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (state != ST_IDLE) begin
        bit_cnt <= bit_end ? '0 : bit_cnt + 1'b1;
      end
      case (state)
        ST_IDLE: begin
          if (valid_in) begin
            state      <= ST_START;
            tx_out     <= 1'b0;
            ready      <= 1'b0;
            busy       <= 1'b1;
            shift_reg  <= data_in;
            parity_bit <= parity_calc;
            bit_cnt    <= '0;
            bit_idx    <= '0;
          end
        end
        ST_START: begin
          if (bit_end) begin
            state     <= ST_DATA;
            tx_out    <= shift_reg[0];
            shift_reg <= shift_reg >> 1;
          end
        end
        ST_DATA: begin
          if (bit_end) begin
            if (bit_idx == IDX_LAST) begin
              state  <= ST_PARITY;
              tx_out <= parity_bit;
            end else begin
              bit_idx   <= bit_idx + 1'b1;
              tx_out    <= shift_reg[0];
              shift_reg <= shift_reg >> 1;
            end
          end
        end
        ST_PARITY: begin
          if (bit_end) begin
            state  <= ST_STOP;
            tx_out <= 1'b1;
          end
        end
        ST_STOP: begin
          if (bit_end) begin
            state      <= ST_IDLE;
            ready      <= 1'b1;
            busy       <= 1'b0;
            frame_done <= 1'b1;
          end
        end
        default: begin
          state  <= ST_IDLE;
          tx_out <= 1'b1;
          ready  <= 1'b1;
          busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_parity_frame_ctrl.sv
// ============================================================================
// tb_parity_frame_ctrl : scoreboard bench for parity_frame_ctrl
// Honours PARITY_ODD_EN when computing expected parity.
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_parity_frame_ctrl;

  localparam int DW = 8;
  localparam int BC = 4;
  localparam int N  = (DW + 3) * BC;

  logic          clk    = 1'b0;
  logic          rst_n  = 1'b1;
  logic [DW-1:0] data   = '0;
  logic          valid  = 1'b0;
  logic          ready, tx, busy, fdone;
  logic [DW-1:0] data1  = '0;
  logic          valid1 = 1'b0;
  logic          ready1, tx1, busy1, fdone1;

  always #5 clk = ~clk;

  parity_frame_ctrl #(.DATA_W(DW), .BIT_CYCLES(BC)) u_dut (
    .clk_in(clk), .rst_n_in(rst_n), .data_in(data), .valid_in(valid),
    .ready(ready), .tx_out(tx), .busy(busy), .frame_done(fdone));

  parity_frame_ctrl #(.DATA_W(DW), .BIT_CYCLES(1)) u_dut_bc1 (
    .clk_in(clk), .rst_n_in(rst_n), .data_in(data1), .valid_in(valid1),
    .ready(ready1), .tx_out(tx1), .busy(busy1), .frame_done(fdone1));

  typedef struct {
    logic [DW+2:0] bits;
    int            acc;
  } frame_t;

  frame_t        exp_q[$];
  frame_t        cur;
  int            cyc       = 0;
  int            next_free = 0;
  int            acc_count = 0;
  int            total     = 0;
  int            passed    = 0;
  bit            mon_active = 1'b0;
  int            pos       = 0;
  logic [DW-1:0] rd;
  logic [DW+2:0] bits1;

  // Frame as transmitted, bit 0 first: start, data LSB first, parity, stop.
  function automatic logic [DW+2:0] frame_bits(input logic [DW-1:0] d);
    int   ones;
    logic p;
    ones = $countones(d);
`ifdef PARITY_ODD_EN
    p = ((ones % 2) == 0);
`else
    p = ((ones % 2) == 1);
`endif
    return {1'b1, p, d, 1'b0};
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: a word is accepted when valid is high and the previous
  // frame plus its done cycle has elapsed.
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (!rst_n) begin
      next_free = 0;
    end else if (valid && cyc >= next_free) begin
      exp_q.push_back('{bits: frame_bits(data), acc: cyc});
      next_free = cyc + N + 1;
      acc_count = acc_count + 1;
    end
  end

  // Monitor: compares the DUT's serial line against popped expectations.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_tx", tx, 1);
      chk("rst_busy", busy, 0);
      chk("rst_ready", ready, 1);
      chk("rst_done", fdone, 0);
      mon_active = 1'b0;
    end else begin
      if (!mon_active && busy) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_frame", 1, 0);
        end else begin
          cur = exp_q.pop_front();
          chk("accept_cycle", cyc, cur.acc);
          mon_active = 1'b1;
          pos = 0;
        end
      end
      if (mon_active) begin
        if (pos < N) begin
          chk("frame_tx", tx, int'(cur.bits[pos / BC]));
          chk("frame_busy", busy, 1);
          chk("frame_ready", ready, 0);
          chk("frame_done_early", fdone, 0);
          pos++;
        end else begin
          chk("done_pulse", fdone, 1);
          chk("done_ready", ready, 1);
          chk("done_busy", busy, 0);
          chk("done_tx", tx, 1);
          mon_active = 1'b0;
        end
      end else if (!busy) begin
        chk("idle_tx", tx, 1);
        chk("idle_ready", ready, 1);
        chk("idle_done", fdone, 0);
        chk("missed_accept", exp_q.size(), 0);
      end
    end
  end

  task automatic send(input logic [DW-1:0] d, input bit hold);
    int start;
    bit ok;
    ok = 1'b0;
    @(negedge clk);
    valid = 1'b1;
    data  = d;
    start = acc_count;
    for (int k = 0; k < 400; k++) begin
      @(posedge clk);
      #1;
      if (acc_count != start) begin
        ok = 1'b1;
        break;
      end
    end
    chk("accept_timeout", ok, 1);
    data = DW'($urandom);
    if (!hold) valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    @(negedge clk);
    valid = 1'b0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      #1;
      if (!mon_active && exp_q.size() == 0 && cyc >= next_free) begin
        ok = 1'b1;
        break;
      end
    end
    chk("idle_timeout", ok, 1);
  endtask

  task automatic busy_pulse(input logic [DW-1:0] d);
    repeat (2) @(negedge clk);
    valid = 1'b1;
    data  = d;
    @(negedge clk);
    valid = 1'b0;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;

    send(8'hA5, 1'b0);
    wait_idle();
    send(8'h07, 1'b0);
    wait_idle();
    send(8'h3C, 1'b1);
    send(8'hFF, 1'b0);
    wait_idle();

    // Abort a frame mid-DATA; reset must act without waiting for a clock.
    send(8'h5A, 1'b0);
    repeat (BC * 3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_tx", tx, 1);
    chk("async_busy", busy, 0);
    chk("async_ready", ready, 1);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    send(8'h01, 1'b0);
    wait_idle();

    send(8'hC3, 1'b0);
    busy_pulse(8'h11);
    wait_idle();

    bits1 = frame_bits(8'h80);
    @(negedge clk);
    valid1 = 1'b1;
    data1  = 8'h80;
    @(posedge clk);
    #1;
    valid1 = 1'b0;
    data1  = 8'h00;
    for (int k = 0; k < DW + 3; k++) begin
      @(negedge clk);
      chk("bc1_tx", tx1, int'(bits1[k]));
      chk("bc1_busy", busy1, 1);
    end
    @(negedge clk);
    chk("bc1_done", fdone1, 1);
    chk("bc1_ready", ready1, 1);
    @(negedge clk);
    chk("bc1_done_clear", fdone1, 0);

    for (int i = 0; i < 30; i++) begin
      rd = DW'($urandom);
      send(rd, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 2) == 0) busy_pulse(DW'($urandom));
      if ($urandom_range(0, 1) == 0) wait_idle();
    end
    wait_idle();
    chk("queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/parity_frame_ctrl.md
PARITY_FRAME_CTRL -- requirements
Module: parity_frame_ctrl

Interface
REQ-001 SHALL provide parameter DATA_W, default 8, payload bits per frame (legal 1..16).
REQ-002 SHALL provide parameter BIT_CYCLES, default 4, clock cycles each serial bit is held (legal >= 1).
REQ-003 SHALL have clk_in  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have rst_n_in  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have data_in  input  DATA_W  payload word, sampled only on handshake.
REQ-006 SHALL have valid_in  input  1  requester has a word on data_in.
REQ-007 SHALL have ready  output  1  block can accept a word this cycle.
REQ-008 SHALL have tx_out  output  1  serial line: start, data LSB first, parity, stop.
REQ-009 SHALL have busy  output  1  a frame is in progress.
REQ-010 SHALL have frame_done  output  1  one-cycle pulse when a stop bit completes.

Function
REQ-011 SHALL implement states IDLE, START, DATA, PARITY, STOP.
REQ-012 SHALL assert ready only in IDLE; busy SHALL equal "state != IDLE".
REQ-013 SHALL accept a word at the rising edge where valid_in=1 and ready=1, latching data_in and the computed parity bit.
REQ-014 SHALL ignore valid_in when ready=0 and SHALL ignore data_in changes after acceptance.
REQ-015 SHALL enter START at the accepting edge, with tx_out=0 from that edge; there is no extra latency cycle.
REQ-016 SHALL hold each bit (start, each data bit, parity, stop=1) for exactly BIT_CYCLES cycles, using a bit-cycle counter and a data-bit index.
REQ-017 SHALL transmit data bits LSB first: START->DATA after BIT_CYCLES, DATA->PARITY after DATA_W bits, PARITY->STOP, STOP->IDLE.
REQ-018 SHALL make one frame occupy exactly (DATA_W+3)*BIT_CYCLES cycles from the accepting edge to the return to IDLE.
REQ-019 SHALL assert frame_done for exactly the one cycle following the STOP->IDLE edge, coincident with ready=1.
REQ-020 SHALL, when valid_in is held high continuously, accept the next word on the first IDLE cycle, giving exactly one idle cycle (tx_out=1) between frames.
REQ-021 SHALL drive tx_out=1 in IDLE and in STOP.
REQ-022 SHALL, with BIT_CYCLES=1, advance one bit per cycle without skipping or repeating any bit.

Reset
REQ-023 SHALL, when rst_n_in=0, immediately force state=IDLE, tx_out=1, ready=1, busy=0, frame_done=0, and counters and data register to 0.
REQ-024 SHALL, when reset is asserted mid-frame, abort the frame with no frame_done pulse, and SHALL not resume the aborted word.
REQ-025 SHALL resume normal handshakes from the first rising edge after rst_n_in deasserts.

Configuration
REQ-026 SHALL, with macro PARITY_ODD_EN defined, transmit odd parity: parity bit = NOT(XOR of the data bits).
REQ-027 SHALL, without PARITY_ODD_EN, transmit even parity: parity bit = XOR of the data bits; no other behaviour differs.

Verification
REQ-028 SHALL cover: even build, DATA_W=8, BIT_CYCLES=4, send 0xA5 -> tx_out sequence 0,1,0,1,0,0,1,0,1,0(parity),1, each held 4 cycles; frame_done at cycle 45.
REQ-029 SHALL cover: send 0x07 -> parity bit 1 in the even build and 0 in the PARITY_ODD_EN build.
REQ-030 SHALL cover: valid_in held high with words 0x3C then 0xFF -> two frames separated by one idle cycle; second parity 0 (even build); ready high only in that idle cycle.
REQ-031 SHALL cover: rst_n_in pulsed low during the DATA state of 0x5A -> tx_out=1 and busy=0 asynchronously; no frame_done; next word 0x01 framed correctly.
REQ-032 SHALL cover: BIT_CYCLES=1, send 0x80 -> 11-cycle frame 0,0,0,0,0,0,0,0,1,1,1.
REQ-033 SHALL cover: valid_in pulsed while busy=1 with data 0x11 -> word ignored; no second frame.
